// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer with tree-PLRU replacement and invalidation sweep
module btb_assoc #(
   parameter int ADDR  = 32,
   parameter int BTB_D = 32,
   parameter int WAYS  = 2,
   parameter int CNT   = 2
) (
   input  logic            clk,
   input  logic            reset_,
   input  logic [ADDR-1:0] pc,
   output logic            btb_hit,
   output logic [ADDR-1:0] btb_addr,
   input  logic            br_commit_,
   input  logic            br_taken_,
   input  logic            br_miss_,
   input  logic            jump_commit_,
   input  logic            jump_miss_,
   input  logic [ADDR-1:0] com_addr,
   input  logic [ADDR-1:0] com_tar_addr,
   input  logic            inv_,
   output logic            btb_busy_
);
   localparam int IDX = $clog2(BTB_D);
   localparam int TW  = ADDR - 2 - IDX;
   localparam int LV  = $clog2(WAYS);
   localparam int WW  = (WAYS > 1) ? LV : 1;
   localparam int PW  = (WAYS > 1) ? WAYS - 1 : 1;
   localparam logic [CNT-1:0] THR = CNT'(1) << (CNT - 1);
   localparam logic [CNT-1:0] LOW = THR - 1'b1;
   localparam logic [CNT-1:0] MAX = '1;

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t          state_q, state_d;
   logic [IDX-1:0]  ptr_q, ptr_d;
   logic [WAYS-1:0] valid_q [BTB_D];
   logic [WAYS-1:0] valid_d [BTB_D];
   logic [TW-1:0]   tag_q [BTB_D][WAYS];
   logic [TW-1:0]   tag_d [BTB_D][WAYS];
   logic [ADDR-1:0] tgt_q [BTB_D][WAYS];
   logic [ADDR-1:0] tgt_d [BTB_D][WAYS];
   logic [CNT-1:0]  cnt_q [BTB_D][WAYS];
   logic [CNT-1:0]  cnt_d [BTB_D][WAYS];
   logic [PW-1:0]   plru_q [BTB_D];
   logic [PW-1:0]   plru_d [BTB_D];

   logic [IDX-1:0]  p_idx, c_idx;
   logic [TW-1:0]   p_tag, c_tag;
   logic            p_hit, c_hit, free;
   logic [WW-1:0]   p_way, c_way, free_way, vic, wway;
   logic [CNT-1:0]  cur, inc, dec;
   logic [PW-1:0]   pv;
   logic            unused;

   assign p_idx  = pc[IDX+1:2];
   assign p_tag  = pc[ADDR-1:IDX+2];
   assign c_idx  = com_addr[IDX+1:2];
   assign c_tag  = com_addr[ADDR-1:IDX+2];
   assign unused = ^{jump_miss_, pc[1:0], com_addr[1:0]};

   // descending scan leaves the lowest-numbered invalid way in free_way
   always_comb begin
      p_hit = 1'b0;
      p_way = '0;
      c_hit = 1'b0;
      c_way = '0;
      free = 1'b0;
      free_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[p_idx][w] && tag_q[p_idx][w] == p_tag) begin p_hit = 1'b1; p_way = WW'(w); end
         if (valid_q[c_idx][w] && tag_q[c_idx][w] == c_tag) begin c_hit = 1'b1; c_way = WW'(w); end
         if (!valid_q[c_idx][w]) begin free = 1'b1; free_way = WW'(w); end
      end
   end

   // PLRU bits point towards the less recently used half at each tree node
   always_comb begin
      int  n;
      logic b;
      vic = '0;
      n = 0;
      b = 1'b0;
      for (int l = 0; l < LV; l++) begin
         b = 1'(plru_q[c_idx] >> n);
         vic = WW'({vic, b});
         n = 2 * n + 1 + int'(b);
      end
   end

   always_comb begin
      int  n;
      logic dir;
      state_d = state_q;
      ptr_d = ptr_q;
      valid_d = valid_q;
      tag_d = tag_q;
      tgt_d = tgt_q;
      cnt_d = cnt_q;
      plru_d = plru_q;
      wway = c_hit ? c_way : free ? free_way : vic;
      cur = cnt_q[c_idx][c_way];
      inc = (cur == MAX) ? MAX : cur + 1'b1;
      inc = (!br_miss_ && inc < THR) ? THR : inc;
      dec = (cur == '0) ? '0 : cur - 1'b1;
      dec = (!br_miss_ && dec > LOW) ? LOW : dec;
      pv = plru_q[c_idx];
      n = 0;
      dir = 1'b0;
      for (int l = 0; l < LV; l++) begin
         dir = 1'(wway >> (LV - 1 - l));
         pv = (pv & ~(PW'(1) << n)) | (PW'(!dir) << n);
         n = 2 * n + 1 + int'(dir);
      end
      if (state_q == SWEEP) begin
         valid_d[ptr_q] = '0;
         plru_d[ptr_q] = '0;
         ptr_d = ptr_q + 1'b1;
         state_d = (ptr_q == IDX'(BTB_D - 1)) ? IDLE : SWEEP;
      end else if (!inv_) begin
         state_d = SWEEP;
         ptr_d = '0;
      end else if (!jump_commit_ || (!br_commit_ && (!br_taken_ || c_hit))) begin
         valid_d[c_idx][wway] = 1'b1;
         tag_d[c_idx][wway] = c_tag;
         if (!jump_commit_ || !br_taken_) tgt_d[c_idx][wway] = com_tar_addr;
         cnt_d[c_idx][wway] = !jump_commit_ ? MAX : !br_taken_ ? (c_hit ? inc : THR) : dec;
         plru_d[c_idx] = pv;
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q <= IDLE;
         ptr_q <= '0;
         for (int s = 0; s < BTB_D; s++) begin
            valid_q[s] <= '0;
            plru_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               tag_q[s][w] <= '0;
               tgt_q[s][w] <= '0;
               cnt_q[s][w] <= '0;
            end
         end
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         valid_q <= valid_d;
         tag_q <= tag_d;
         tgt_q <= tgt_d;
         cnt_q <= cnt_d;
         plru_q <= plru_d;
      end
   end

   assign btb_busy_ = (state_q != SWEEP);
   assign btb_hit   = btb_busy_ && p_hit && cnt_q[p_idx][p_way] >= THR;
   assign btb_addr  = btb_hit ? tgt_q[p_idx][p_way] : '0;
endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: randomized and directed checks of btb_assoc against an LRU-table reference model
module tb_btb_assoc;
   localparam int D = 32, W = 2, THR = 2, MAX = 3;

   logic        clk = 1'b0, reset_ = 1'b0;
   logic        br_commit_ = 1'b1, br_taken_ = 1'b1, br_miss_ = 1'b1;
   logic        jump_commit_ = 1'b1, jump_miss_ = 1'b1, inv_ = 1'b1;
   logic [31:0] pc = '0, com_addr = '0, com_tar_addr = '0, btb_addr;
   logic        btb_hit, btb_busy_;
   int          n_checks = 0, n_errors = 0;

   bit          mv [D][W];
   int unsigned mtag [D][W];
   logic [31:0] mtgt [D][W];
   int          mcnt [D][W];
   longint      mst [D][W];
   longint      now = 0;
   int          msweep = 0;

   always #5 clk = ~clk;

   btb_assoc dut (
      .clk(clk), .reset_(reset_), .pc(pc), .btb_hit(btb_hit), .btb_addr(btb_addr),
      .br_commit_(br_commit_), .br_taken_(br_taken_), .br_miss_(br_miss_),
      .jump_commit_(jump_commit_), .jump_miss_(jump_miss_), .com_addr(com_addr),
      .com_tar_addr(com_tar_addr), .inv_(inv_), .btb_busy_(btb_busy_)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void mclear();
      for (int s = 0; s < D; s++)
         for (int w = 0; w < W; w++) begin
            mv[s][w] = 0;
            mst[s][w] = 0;
         end
   endfunction

   function automatic int mfind(input logic [31:0] a);
      int s = (a >> 2) % D;
      for (int w = 0; w < W; w++)
         if (mv[s][w] && mtag[s][w] == (a >> 7)) return w;
      return -1;
   endfunction

   function automatic void mlook(input logic [31:0] a, output bit h, output logic [31:0] t);
      int w = mfind(a);
      int s = (a >> 2) % D;
      h = (msweep == 0) && w >= 0 && mcnt[s][w] >= THR;
      t = h ? mtgt[s][w] : 32'h0;
   endfunction

   // training rules expressed directly on counter values; victim is least recently written way
   function automatic void mwrite(input logic [31:0] a, input logic [31:0] tar, input bit jump, input bit taken, input bit miss);
      int s = (a >> 2) % D;
      int w = mfind(a);
      if (w < 0 && !jump && !taken) return;
      if (w < 0) begin
         for (int i = W - 1; i >= 0; i--) if (!mv[s][i]) w = i;
         if (w < 0) begin
            w = 0;
            for (int i = 1; i < W; i++) if (mst[s][i] < mst[s][w]) w = i;
         end
         mv[s][w] = 1;
         mtag[s][w] = a >> 7;
         mtgt[s][w] = tar;
         mcnt[s][w] = jump ? MAX : THR;
      end else if (jump) begin
         mtgt[s][w] = tar;
         mcnt[s][w] = MAX;
      end else if (taken) begin
         mtgt[s][w] = tar;
         mcnt[s][w] = (mcnt[s][w] + 1 > MAX) ? MAX : mcnt[s][w] + 1;
         if (miss && mcnt[s][w] < THR) mcnt[s][w] = THR;
      end else begin
         mcnt[s][w] = (mcnt[s][w] > 0) ? mcnt[s][w] - 1 : 0;
         if (miss && mcnt[s][w] > THR - 1) mcnt[s][w] = THR - 1;
      end
      now++;
      mst[s][w] = now;
   endfunction

   function automatic void mupdate();
      if (msweep > 0) msweep--;
      else if (!inv_) begin msweep = D; mclear(); end
      else if (!jump_commit_) mwrite(com_addr, com_tar_addr, 1, 1, 0);
      else if (!br_commit_) mwrite(com_addr, com_tar_addr, 0, !br_taken_, !br_miss_);
   endfunction

   task automatic tick();
      bit          h;
      logic [31:0] t;
      #1;
      mlook(pc, h, t);
      check("busy_", {31'h0, btb_busy_}, {31'h0, msweep == 0});
      check("hit", {31'h0, btb_hit}, {31'h0, h});
      check("addr", btb_addr, t);
      @(posedge clk);
      mupdate();
      @(negedge clk);
   endtask

   task automatic idle();
      br_commit_ = 1'b1; br_taken_ = 1'b1; br_miss_ = 1'b1;
      jump_commit_ = 1'b1; jump_miss_ = 1'b1; inv_ = 1'b1;
   endtask

   task automatic jump(input logic [31:0] a, input logic [31:0] t);
      idle();
      jump_commit_ = 1'b0; com_addr = a; com_tar_addr = t;
      tick();
      idle();
   endtask

   task automatic br(input logic [31:0] a, input logic [31:0] t, input bit taken, input bit miss);
      idle();
      br_commit_ = 1'b0; br_taken_ = !taken; br_miss_ = !miss; com_addr = a; com_tar_addr = t;
      tick();
      idle();
   endtask

   task automatic look(input logic [31:0] a, input bit eh, input logic [31:0] ea);
      pc = a;
      #1;
      check("look_hit", {31'h0, btb_hit}, {31'h0, eh});
      check("look_addr", btb_addr, ea);
   endtask

   task automatic do_reset();
      reset_ = 1'b0;
      #1;
      check("rst_busy_", {31'h0, btb_busy_}, 32'h1);
      check("rst_hit", {31'h0, btb_hit}, 32'h0);
      check("rst_addr", btb_addr, 32'h0);
      mclear();
      msweep = 0;
      @(negedge clk);
      reset_ = 1'b1;
   endtask

   function automatic logic [31:0] raddr();
      return (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3));
   endfunction

   initial begin
      int lows, hits;
      @(negedge clk);
      do_reset();

      jump(32'hdeadbe74, 32'hcafecafc);
      look(32'hdeadbe74, 1, 32'hcafecafc);
      look(32'hdeadbe78, 0, 32'h0);

      do_reset();
      br(32'h100, 32'h2000, 1, 0);
      look(32'h100, 1, 32'h2000);
      br(32'h100, 32'h2000, 0, 0);
      look(32'h100, 0, 32'h0);
      br(32'h100, 32'h2000, 1, 0);
      br(32'h100, 32'h2000, 1, 0);
      br(32'h100, 32'h2000, 0, 0);
      look(32'h100, 1, 32'h2000);
      br(32'h100, 32'h2000, 1, 0);
      br(32'h100, 32'h2000, 0, 1);
      look(32'h100, 0, 32'h0);
      br(32'h204, 32'h3000, 0, 0);
      look(32'h204, 0, 32'h0);
      br(32'h100, 32'h2400, 1, 0);
      look(32'h100, 1, 32'h2400);
      br(32'h100, 32'h2400, 0, 0);
      br(32'h100, 32'h2400, 0, 0);
      br(32'h100, 32'h2800, 1, 1);
      look(32'h100, 1, 32'h2800);

      do_reset();
      jump(32'h000, 32'h1000);
      jump(32'h080, 32'h1080);
      jump(32'h100, 32'h1100);
      look(32'h000, 0, 32'h0);
      look(32'h080, 1, 32'h1080);
      look(32'h100, 1, 32'h1100);
      jump(32'h080, 32'h1880);
      jump(32'h180, 32'h1180);
      look(32'h100, 0, 32'h0);
      look(32'h080, 1, 32'h1880);
      look(32'h180, 1, 32'h1180);

      do_reset();
      jump_commit_ = 1'b0; br_commit_ = 1'b0; br_taken_ = 1'b0; br_miss_ = 1'b0;
      com_addr = 32'h300; com_tar_addr = 32'h4300;
      tick();
      idle();
      br(32'h300, 32'h4300, 0, 0);
      look(32'h300, 1, 32'h4300);

      do_reset();
      for (int i = 0; i < 4; i++) jump(32'h10 + 32'(4 * i), 32'h40 + 32'(4 * i));
      look(32'h10, 1, 32'h40);
      inv_ = 1'b0;
      tick();
      idle();
      lows = 0;
      hits = 0;
      for (int i = 0; i < D; i++) begin
         if (!btb_busy_) lows++;
         if (btb_hit) hits++;
         if (i == 10) begin jump_commit_ = 1'b0; com_addr = 32'h500; com_tar_addr = 32'h600; end
         tick();
         idle();
      end
      check("sweep_len", 32'(lows), 32'(D));
      check("sweep_hits", 32'(hits), 32'h0);
      check("sweep_done", {31'h0, btb_busy_}, 32'h1);
      for (int i = 0; i < 4; i++) look(32'h10 + 32'(4 * i), 0, 32'h0);
      look(32'h500, 0, 32'h0);
      jump(32'h14, 32'h777c);
      look(32'h14, 1, 32'h777c);

      jump(32'h10, 32'h40);
      inv_ = 1'b0;
      tick();
      idle();
      for (int i = 0; i < 5; i++) tick();
      pc = 32'h10;
      do_reset();
      look(32'h10, 0, 32'h0);
      look(32'h14, 0, 32'h0);
      tick();

      for (int i = 0; i < 3000; i++) begin
         int r = $urandom_range(0, 299);
         idle();
         com_addr = raddr();
         com_tar_addr = $urandom;
         pc = raddr();
         jump_miss_ = 1'($urandom);
         if (r < 60) jump_commit_ = 1'b0;
         if (r >= 40 && r < 200) begin
            br_commit_ = 1'b0;
            br_taken_ = 1'($urandom);
            br_miss_ = ($urandom_range(0, 3) != 0);
         end
         if (r >= 297) inv_ = 1'b0;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
